// File: rtl/creador_float_pkg.sv
// Shared widths and the binary16 field layout for the int8 -> half converter.
package creador_float_pkg;

  localparam int IN_W        = 8;
  localparam int HALF_BIAS   = 15;
  localparam int HALF_EXP_W  = 5;
  localparam int HALF_FRAC_W = 10;
  localparam int HALF_W      = 1 + HALF_EXP_W + HALF_FRAC_W;

  typedef struct packed {
    logic                   sign;
    logic [HALF_EXP_W-1:0]  exp;
    logic [HALF_FRAC_W-1:0] frac;
  } half_t;

endpackage

// File: rtl/creador_float_if.sv
// AXI4-Stream style operand/result channels of the int8 -> binary16 converter.
interface creador_float_if import creador_float_pkg::*; ();

  logic              s_axis_a_tvalid;
  logic              s_axis_a_tready;
  logic [IN_W-1:0]   s_axis_a_tdata;
  logic              m_axis_result_tvalid;
  logic              m_axis_result_tready;
  logic [HALF_W-1:0] m_axis_result_tdata;

  modport slave (
    input  s_axis_a_tvalid, s_axis_a_tdata, m_axis_result_tready,
    output s_axis_a_tready, m_axis_result_tvalid, m_axis_result_tdata
  );

  modport master (
    output s_axis_a_tvalid, s_axis_a_tdata, m_axis_result_tready,
    input  s_axis_a_tready, m_axis_result_tvalid, m_axis_result_tdata
  );

endinterface

// File: rtl/creador_float_lod8.sv
// Combinational leading-one detector: position of the highest set bit plus an all-zero flag.
module creador_float_lod8 import creador_float_pkg::*; (
  input  logic [IN_W-1:0] vec,
  output logic [2:0]      pos,
  output logic            zero
);

  always_comb begin
    pos  = 3'd0;
    zero = (vec == '0);
    // Ascending scan so the highest set bit wins.
    for (int i = 0; i < IN_W; i++) begin
      if (vec[i]) pos = 3'(i);
    end
  end

endmodule

// File: rtl/creador_float.sv
// Streaming int8 (two's complement) to IEEE-754 binary16 converter, two register stages.
module creador_float import creador_float_pkg::*; (
  input  logic            aclk,
  input  logic            areset,
  creador_float_if.slave  bus
);

  logic                    en;
  logic signed [IN_W-1:0]  din_s;

  logic                    vld_p1_q, vld_p1_d;
  logic                    sign_p1_q, sign_p1_d;
  logic        [IN_W-1:0]  mag_p1_q, mag_p1_d;

  logic                    vld_p2_q, vld_p2_d;
  half_t                   res_p2_q, res_p2_d;

  logic [2:0]              lead_pos;
  logic                    lead_zero;

  // -128 has no positive int8 twin; reading the result unsigned gives 128.
  function automatic logic [IN_W-1:0] abs_mag(input logic signed [IN_W-1:0] d);
    logic [IN_W-1:0] u;
    u = d;
    return d[IN_W-1] ? (~u + IN_W'(1)) : u;
  endfunction

  // Every int8 magnitude fits the 11-bit significand, so packing is exact.
  function automatic half_t pack_half(input logic            s,
                                      input logic [IN_W-1:0] mag,
                                      input logic [2:0]      p,
                                      input logic            z);
    half_t       h;
    logic [17:0] sh;
    sh     = {10'b0, mag} << (4'd10 - {1'b0, p});
    h.sign = s;
    h.exp  = HALF_EXP_W'(p) + HALF_EXP_W'(HALF_BIAS);
    h.frac = sh[HALF_FRAC_W-1:0];
    if (z) h = '0;
    return h;
  endfunction

  creador_float_lod8 u_lod8 (
    .vec  (mag_p1_q),
    .pos  (lead_pos),
    .zero (lead_zero)
  );

  always_comb begin
    en        = !vld_p2_q || bus.m_axis_result_tready;
    din_s     = bus.s_axis_a_tdata;
    vld_p1_d  = vld_p1_q;
    sign_p1_d = sign_p1_q;
    mag_p1_d  = mag_p1_q;
    vld_p2_d  = vld_p2_q;
    res_p2_d  = res_p2_q;
    if (en) begin
      vld_p1_d  = bus.s_axis_a_tvalid;
      sign_p1_d = din_s[IN_W-1];
      mag_p1_d  = abs_mag(din_s);
      vld_p2_d  = vld_p1_q;
      res_p2_d  = pack_half(sign_p1_q, mag_p1_q, lead_pos, lead_zero);
    end
  end

  // Stage 1 boundary: sign and magnitude, data only.
  always_ff @(posedge aclk) begin
    sign_p1_q <= sign_p1_d;
    mag_p1_q  <= mag_p1_d;
  end

  // Stage 2 boundary: valids plus the output word, which must read zero out of reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      res_p2_q <= res_p2_d;
    end
  end

  assign bus.s_axis_a_tready      = en && !areset;
  assign bus.m_axis_result_tvalid = vld_p2_q;
  assign bus.m_axis_result_tdata  = res_p2_q;

endmodule

// File: tb/tb_creador_float.sv
// Directed and randomized checks of creador_float against hand values and a real-valued model.
module tb_creador_float;

  logic aclk;
  logic areset;

  creador_float_if bus ();

  creador_float dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          ncmp  = 0;
  int          nfail = 0;
  int          n_acc = 0;
  string       cur_tag;
  logic [15:0] exp_q[$];

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference: normalise a real value by repeated halving.
  function automatic logic [15:0] model(input logic [7:0] d);
    logic signed [7:0] ds;
    int   v;
    int   e;
    int   frac;
    real  r;
    logic s;
    ds = d;
    v  = ds;
    if (v == 0) return 16'h0000;
    s = (v < 0);
    r = $itor(s ? -v : v);
    e = 0;
    while (r >= 2.0) begin
      r = r / 2.0;
      e++;
    end
    frac = $rtoi((r - 1.0) * 1024.0);
    return {s, 5'(e + 15), 10'(frac)};
  endfunction

  // Called at a negedge; drives one cycle, scores both handshakes, returns at the next negedge.
  task automatic drive_cycle(input bit v, input logic [7:0] d, input bit rdy, input logic [15:0] e);
    bus.s_axis_a_tvalid      = v;
    bus.s_axis_a_tdata       = d;
    bus.m_axis_result_tready = rdy;
    #1;
    if (bus.m_axis_result_tvalid && rdy) begin
      if (exp_q.size() != 0) check16(cur_tag, bus.m_axis_result_tdata, exp_q.pop_front());
      else check16({cur_tag, "_unexpected_beat"}, 16'(exp_q.size()), 16'd1);
    end
    if (v && bus.s_axis_a_tready) begin
      exp_q.push_back(e);
      n_acc++;
    end
    @(negedge aclk);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) drive_cycle(1'b0, 8'h00, 1'b1, 16'h0000);
    check16({cur_tag, "_drained"}, 16'(exp_q.size()), 16'h0000);
  endtask

  initial begin
    logic [7:0] d;
    bit         v;
    bit         r;
    areset                   = 1'b1;
    bus.s_axis_a_tvalid      = 1'b0;
    bus.s_axis_a_tdata       = 8'h00;
    bus.m_axis_result_tready = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    check16("rst_tvalid", {15'b0, bus.m_axis_result_tvalid}, 16'h0000);
    check16("rst_tdata",  bus.m_axis_result_tdata, 16'h0000);
    check16("rst_tready", {15'b0, bus.s_axis_a_tready}, 16'h0000);

    areset = 1'b0;
    @(negedge aclk);
    check16("post_rst_tvalid", {15'b0, bus.m_axis_result_tvalid}, 16'h0000);
    check16("post_rst_tdata",  bus.m_axis_result_tdata, 16'h0000);

    // Steady stream of 63: nothing after the accepting edge, valid after the next one.
    cur_tag = "hold_3f";
    drive_cycle(1'b1, 8'h3F, 1'b1, 16'h53E0);
    check16("lat_not_yet", {15'b0, bus.m_axis_result_tvalid}, 16'h0000);
    drive_cycle(1'b1, 8'h3F, 1'b1, 16'h53E0);
    check16("lat_valid", {15'b0, bus.m_axis_result_tvalid}, 16'h0001);
    check16("lat_data",  bus.m_axis_result_tdata, 16'h53E0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'h3F, 1'b1, 16'h53E0);
    drain();

    cur_tag = "directed";
    drive_cycle(1'b1, 8'h01, 1'b1, 16'h3C00);
    drive_cycle(1'b1, 8'hFF, 1'b1, 16'hBC00);
    drive_cycle(1'b1, 8'h00, 1'b1, 16'h0000);
    drive_cycle(1'b1, 8'h7F, 1'b1, 16'h57F0);
    drive_cycle(1'b1, 8'h80, 1'b1, 16'hD800);
    drain();

    cur_tag = "sweep";
    for (int i = 0; i < 256; i++) drive_cycle(1'b1, 8'(i), 1'b1, model(8'(i)));
    drain();

    // Backpressure with 0x3F, 0x01 in flight and 0xFF waiting.
    cur_tag = "backpressure";
    drive_cycle(1'b1, 8'h3F, 1'b0, 16'h53E0);
    drive_cycle(1'b1, 8'h01, 1'b0, 16'h3C00);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 8'hFF, 1'b0, 16'hBC00);
      check16("bp_tready", {15'b0, bus.s_axis_a_tready}, 16'h0000);
      check16("bp_tvalid", {15'b0, bus.m_axis_result_tvalid}, 16'h0001);
      check16("bp_tdata",  bus.m_axis_result_tdata, 16'h53E0);
    end
    drive_cycle(1'b1, 8'hFF, 1'b1, 16'hBC00);
    drain();

    cur_tag = "random";
    n_acc   = 0;
    for (int c = 0; c < 10000 && n_acc < 1000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      drive_cycle(v, d, r, model(d));
    end
    check16("random_beats", {15'b0, (n_acc >= 1000)}, 16'h0001);
    drain();

    // Reset with beats in flight: they must vanish, and the first new input comes out first.
    cur_tag = "reset_mid";
    drive_cycle(1'b1, 8'h3F, 1'b0, 16'h53E0);
    drive_cycle(1'b1, 8'h01, 1'b0, 16'h3C00);
    areset = 1'b1;
    bus.s_axis_a_tvalid = 1'b0;
    #1;
    check16("midrst_tvalid", {15'b0, bus.m_axis_result_tvalid}, 16'h0000);
    check16("midrst_tready", {15'b0, bus.s_axis_a_tready}, 16'h0000);
    check16("midrst_tdata",  bus.m_axis_result_tdata, 16'h0000);
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    exp_q.delete();
    @(negedge aclk);
    drive_cycle(1'b1, 8'h7F, 1'b1, 16'h57F0);
    drive_cycle(1'b1, 8'h80, 1'b1, 16'hD800);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
